// File: rtl/ebus_dev_responder.sv
// EBUS device responder: decodes controller select/function, runs the
// demand/transfer handshake, and models a simple device with a data register,
// busy/done status and a PI request level.
module ebus_dev_responder #(
  parameter logic [0:6]  DEV_CS      = 7'o10,
  parameter int unsigned ACK_DELAY   = 2,
  parameter int unsigned BUSY_CYCLES = 16,
  parameter logic [0:17] IVEC        = 18'o000040
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:6]  ebus_cs,
  input  logic [0:2]  ebus_func,
  input  logic        ebus_demand,
  input  logic [0:35] ebus_data_in,
  output logic        ebus_xfer,
  output logic        ebus_drive,
  output logic [0:35] ebus_data_out,
  output logic [0:7]  ebus_pi
);

  localparam int unsigned DLY_W  = 4;
  localparam int unsigned BCNT_W = 16;
  localparam int unsigned DATA_W = 36;
  localparam int unsigned PI_W   = 8;
  localparam int unsigned LVL_W  = 3;

  localparam logic [0:2] F_CONO  = 3'b000;
  localparam logic [0:2] F_CONI  = 3'b001;
  localparam logic [0:2] F_DATAO = 3'b010;
  localparam logic [0:2] F_DATAI = 3'b011;
  localparam logic [0:2] F_PISV  = 3'b100;

  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

  state_t              state_q, state_d;
  logic [0:2]          func_q, func_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [0:DATA_W-1]   data_q, data_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic                xfer_q, xfer_d;
  logic                drive_q, drive_d;
  logic [0:DATA_W-1]   dout_q, dout_d;
  logic [0:PI_W-1]     pi_q, pi_d;

  logic                capture;
  logic                pi_ok;
  logic                func_ok;
  logic                is_read;
  logic                start;
  logic                clr_done;
  logic                complete;
  logic [0:DATA_W-1]   read_word;

  assign pi_ok   = done_q && (level_q != '0);
  assign func_ok = (ebus_func == F_CONO) || (ebus_func == F_CONI) ||
                   (ebus_func == F_DATAO) || (ebus_func == F_DATAI) ||
                   ((ebus_func == F_PISV) && pi_ok);
  assign is_read = (func_q == F_CONI) || (func_q == F_DATAI) || (func_q == F_PISV);

  // Handshake FSM next state; capture marks the edge that enters XFER.
  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    dly_d   = dly_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (ebus_demand && (ebus_cs == DEV_CS) && func_ok) begin
          state_d = WAIT;
          func_d  = ebus_func;
          dly_d   = DLY_W'(ACK_DELAY);
        end
      end
      WAIT: begin
        if (!ebus_demand) begin
          state_d = IDLE;
        end else if (dly_q == '0) begin
          state_d = XFER;
          capture = 1'b1;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      XFER: begin
        if (!ebus_demand) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Device datapath: write effects, busy timer, PI line and read mux.
  always_comb begin
    start     = capture && ((func_q == F_DATAO) || ((func_q == F_CONO) && ebus_data_in[31]));
    clr_done  = capture && (func_q == F_CONO) && ebus_data_in[30];
    complete  = busy_q && (bcnt_q == BCNT_W'(1));

    data_d  = data_q;
    level_d = level_q;
    if (capture && (func_q == F_DATAO)) data_d = ebus_data_in;
    if (capture && (func_q == F_CONO)) begin
      if (ebus_data_in[29]) data_d = '0;
      level_d = ebus_data_in[33:35];
    end

    busy_d = busy_q;
    done_d = done_q;
    bcnt_d = bcnt_q;
    if (start) begin
      busy_d = 1'b1;
      done_d = 1'b0;
      bcnt_d = BCNT_W'(BUSY_CYCLES);
    end else begin
      if (busy_q) bcnt_d = bcnt_q - BCNT_W'(1);
      if (complete) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else if (clr_done) begin
        done_d = 1'b0;
      end
    end

    pi_d = '0;
    if (pi_ok) pi_d[level_q] = 1'b1;

    read_word = '0;
    case (func_q)
      F_CONI: begin
        read_word[30]    = done_q;
        read_word[31]    = busy_q;
        read_word[32]    = |pi_q;
        read_word[33:35] = level_q;
      end
      F_DATAI: read_word = data_q;
      default: read_word = {18'b0, IVEC};
    endcase

    xfer_d  = (state_q == XFER) && ebus_demand;
    drive_d = xfer_d && is_read;
    dout_d  = drive_d ? read_word : '0;
  end

  // All state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      func_q  <= '0;
      dly_q   <= '0;
      data_q  <= '0;
      level_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcnt_q  <= '0;
      xfer_q  <= 1'b0;
      drive_q <= 1'b0;
      dout_q  <= '0;
      pi_q    <= '0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      dly_q   <= dly_d;
      data_q  <= data_d;
      level_q <= level_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcnt_q  <= bcnt_d;
      xfer_q  <= xfer_d;
      drive_q <= drive_d;
      dout_q  <= dout_d;
      pi_q    <= pi_d;
    end
  end

  assign ebus_xfer     = xfer_q;
  assign ebus_drive    = drive_q;
  assign ebus_data_out = dout_q;
  assign ebus_pi       = pi_q;

endmodule

// File: tb/tb_ebus_dev_responder.sv
// Bench for ebus_dev_responder: directed EBUS transactions, a cycle-counting
// reference model checked every cycle, and literal expectations at key points.
module tb_ebus_dev_responder;

  localparam int          D   = 2;
  localparam int          BC  = 16;
  localparam logic [6:0]  DEV = 7'o10;
  localparam logic [17:0] IV  = 18'o000040;
  localparam logic [35:0] PAT = 36'o123456765432;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:6]  ebus_cs = '0;
  logic [0:2]  ebus_func = '0;
  logic        ebus_demand = 1'b0;
  logic [0:35] ebus_data_in = '0;
  logic        ebus_xfer;
  logic        ebus_drive;
  logic [0:35] ebus_data_out;
  logic [0:7]  ebus_pi;

  ebus_dev_responder #(
    .DEV_CS(DEV), .ACK_DELAY(D), .BUSY_CYCLES(BC), .IVEC(IV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ebus_cs(ebus_cs), .ebus_func(ebus_func),
    .ebus_demand(ebus_demand), .ebus_data_in(ebus_data_in),
    .ebus_xfer(ebus_xfer), .ebus_drive(ebus_drive),
    .ebus_data_out(ebus_data_out), .ebus_pi(ebus_pi)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  int ncyc    = 0;
  bit run     = 1'b0;

  task automatic chk(input string nm, input logic [35:0] got, input logic [35:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0o expected %0o (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time-based view: a transaction is "accepted at cycle t_acc"; data moves
  // D+1 edges later and xfer is seen from D+2 edges on. Busy is a deadline.
  int          cyc, t_acc, busy_end;
  bit          in_txn, m_busy, m_done;
  int          m_func;
  logic [2:0]  m_level;
  logic [35:0] m_data;
  bit          exp_xfer, exp_drive;
  logic [35:0] exp_data;
  logic [7:0]  exp_pi;

  task automatic m_reset();
    cyc = 0; t_acc = 0; busy_end = 0; in_txn = 0; m_busy = 0; m_done = 0;
    m_func = 0; m_level = 0; m_data = 0;
    exp_xfer = 0; exp_drive = 0; exp_data = 0; exp_pi = 0;
  endtask

  task automatic m_step();
    int k, f;
    bit nx, nd, start, clr, fin;
    logic [35:0] word, din;
    logic [7:0]  npi;
    cyc++;
    k   = cyc - t_acc;
    din = ebus_data_in;
    f   = int'(ebus_func);
    nx  = in_txn && ebus_demand && (k >= D + 2);
    nd  = nx && (m_func == 1 || m_func == 3 || m_func == 4);
    if (m_func == 1)
      word = 36'(m_done) * 32 + 36'(m_busy) * 16 + 36'(exp_pi != 0) * 8 + 36'(m_level);
    else if (m_func == 3)
      word = m_data;
    else
      word = 36'(IV);
    npi = (m_done && m_level != 0) ? (8'h80 >> m_level) : 8'h00;
    start = 0; clr = 0;
    if (in_txn) begin
      if (!ebus_demand) in_txn = 0;
      else if (k == D + 1) begin
        if (m_func == 2) begin m_data = din; start = 1; end
        if (m_func == 0) begin
          if (din[6]) m_data = 0;
          clr = din[5]; start = din[4]; m_level = din[2:0];
        end
      end
    end else if (ebus_demand && ebus_cs == DEV &&
                 (f <= 3 || (f == 4 && m_done && m_level != 0))) begin
      in_txn = 1; t_acc = cyc; m_func = f;
    end
    fin = m_busy && (cyc == busy_end);
    if (start) begin m_busy = 1; busy_end = cyc + BC; m_done = 0; end
    else if (fin) begin m_busy = 0; m_done = 1; end
    else if (clr) m_done = 0;
    exp_xfer = nx; exp_drive = nd; exp_data = nd ? word : 36'h0; exp_pi = npi;
  endtask

  initial m_reset();

  // Model advances on every active edge, or resets with the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step();
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (run) begin
      chk("xfer", 36'(ebus_xfer), 36'(exp_xfer));
      chk("drive", 36'(ebus_drive), 36'(exp_drive));
      chk("data_out", ebus_data_out, exp_data);
      chk("pi", 36'(ebus_pi), 36'(exp_pi));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    ncyc++;
  endtask

  task automatic txn(input logic [6:0] cs, input logic [2:0] fn, input logic [35:0] din,
                     output bit got, output int lat, output logic [35:0] rd,
                     output logic dr, output int xc);
    ebus_cs = cs; ebus_func = fn; ebus_data_in = din; ebus_demand = 1'b1;
    got = 0; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ebus_xfer) begin got = 1; lat = i - 1; break; end
    end
    rd = ebus_data_out; dr = ebus_drive; xc = ncyc;
    if (got) tick();
    ebus_demand = 1'b0; ebus_cs = '0; ebus_func = '0; ebus_data_in = '0;
    tick();
  endtask

  task automatic noresp(input logic [6:0] cs, input logic [2:0] fn, input int n, output int hits);
    ebus_cs = cs; ebus_func = fn; ebus_data_in = 36'o777; ebus_demand = 1'b1;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ebus_xfer || ebus_drive) hits++;
    end
    ebus_demand = 1'b0; ebus_cs = '0; ebus_func = '0; ebus_data_in = '0;
    tick();
  endtask

  bit          got;
  int          lat, xc, hits;
  logic [35:0] rd;
  logic        dr;

  initial begin
    tick(); tick();
    chk("reset_xfer", 36'(ebus_xfer), 36'h0);
    chk("reset_drive", 36'(ebus_drive), 36'h0);
    chk("reset_data", ebus_data_out, 36'h0);
    chk("reset_pi", 36'(ebus_pi), 36'h0);
    run = 1'b1;
    rst_n = 1'b1;
    tick();

    // DATAO then DATAI read-back
    txn(DEV, 3'b010, PAT, got, lat, rd, dr, xc);
    chk("datao_ack", 36'(got), 36'h1);
    chk("datao_latency", 36'(lat), 36'd4);
    txn(DEV, 3'b011, 36'h0, got, lat, rd, dr, xc);
    chk("datai_data", rd, PAT);
    chk("datai_drive", 36'(dr), 36'h1);
    chk("datai_release", ebus_data_out, 36'h0);

    // Wrong select and unused function get no response
    noresp(7'o11, 3'b011, 50, hits);
    chk("wrong_cs", 36'(hits), 36'h0);
    noresp(DEV, 3'b110, 50, hits);
    chk("bad_func", 36'(hits), 36'h0);

    // CONO start with PI level 5; done after BC cycles, PI line next cycle
    txn(DEV, 3'b000, 36'o25, got, lat, rd, dr, xc);
    for (int i = 0; i < 40 && ebus_pi == 8'h00; i++) tick();
    chk("busy_len", 36'(ncyc - xc), 36'd16);
    chk("pi_line", 36'(ebus_pi), 36'b00000100);
    txn(DEV, 3'b001, 36'h0, got, lat, rd, dr, xc);
    chk("coni_done", rd, 36'o55);

    // PI serve, clear done, second serve rejected
    txn(DEV, 3'b100, 36'h0, got, lat, rd, dr, xc);
    chk("pi_serve_ack", 36'(got), 36'h1);
    chk("pi_serve_data", rd, 36'o000000000040);
    txn(DEV, 3'b000, 36'o45, got, lat, rd, dr, xc);
    chk("pi_cleared", 36'(ebus_pi), 36'h0);
    noresp(DEV, 3'b100, 10, hits);
    chk("pi_serve_rejected", 36'(hits), 36'h0);

    // Demand dropped while waiting: no write
    ebus_cs = DEV; ebus_func = 3'b010; ebus_data_in = 36'o707070707070; ebus_demand = 1'b1;
    tick(); tick();
    ebus_demand = 1'b0; ebus_cs = '0; ebus_func = '0; ebus_data_in = '0;
    tick(); tick();
    txn(DEV, 3'b011, 36'h0, got, lat, rd, dr, xc);
    chk("abort_no_write", rd, PAT);

    // Reset in the middle of a read transfer
    ebus_cs = DEV; ebus_func = 3'b011; ebus_demand = 1'b1;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ebus_xfer) begin got = 1; break; end
    end
    chk("rst_xfer_reached", 36'(got), 36'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_xfer_drop", 36'(ebus_xfer), 36'h0);
    chk("rst_drive_drop", 36'(ebus_drive), 36'h0);
    chk("rst_data_drop", ebus_data_out, 36'h0);
    ebus_demand = 1'b0; ebus_cs = '0; ebus_func = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    txn(DEV, 3'b010, 36'o777, got, lat, rd, dr, xc);
    chk("post_rst_ack", 36'(got), 36'h1);
    txn(DEV, 3'b011, 36'h0, got, lat, rd, dr, xc);
    chk("post_rst_data", rd, 36'o777);

    // Clear-done lands on the completion edge: completion wins
    txn(DEV, 3'b000, 36'o25, got, lat, rd, dr, xc);
    while (ncyc < xc + 11) tick();
    txn(DEV, 3'b000, 36'o45, got, lat, rd, dr, xc);
    txn(DEV, 3'b001, 36'h0, got, lat, rd, dr, xc);
    chk("clr_vs_done", rd, 36'o55);

    // Start lands on the completion edge: start wins
    txn(DEV, 3'b000, 36'o25, got, lat, rd, dr, xc);
    while (ncyc < xc + 11) tick();
    txn(DEV, 3'b000, 36'o25, got, lat, rd, dr, xc);
    txn(DEV, 3'b001, 36'h0, got, lat, rd, dr, xc);
    chk("start_vs_done", rd, 36'o25);
    for (int i = 0; i < 40 && ebus_pi == 8'h00; i++) tick();
    chk("restart_pi", 36'(ebus_pi), 36'b00000100);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
